// File: rtl/orb_descriptor_reader.sv
// rtl/orb_descriptor_reader.sv - ORB descriptor drain and 32-bit word stream serialiser
//
// Pops one descriptor at a time from the upstream FIFO and emits it as a
// 9-word packet: a coordinate header {y, x} followed by the 256-bit
// descriptor, least-significant word first. Corners reported upstream are
// counted against descriptors read; once the frame has ended and both counts
// agree, a single trailer word {16'hFFFF, descriptor_count} is emitted.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_begin_frame_reset         clears frame counters and frame-end flag
//   in_corner_count_increment    one more descriptor is owed this frame
//   in_frame_end                 frame pixels exhausted
//   in_valid, in_descriptor,
//   in_feature_x, in_feature_y   head of the upstream descriptor FIFO
//   out_consume                  pop strobe for the upstream FIFO
//   out_word, out_valid,
//   out_last, in_ready           downstream word stream
//   out_busy                     a packet or trailer is in flight
//   out_descriptor_count         descriptors read in the current frame

module orb_descriptor_reader #(
  parameter int COORD_BITS = 11,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_begin_frame_reset,
  input  logic                  in_corner_count_increment,
  input  logic                  in_frame_end,
  input  logic                  in_valid,
  input  logic [255:0]          in_descriptor,
  input  logic [COORD_BITS-1:0] in_feature_x,
  input  logic [COORD_BITS-1:0] in_feature_y,
  output logic                  out_consume,
  output logic [31:0]           out_word,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  in_ready,
  output logic                  out_busy,
  output logic [COUNT_BITS-1:0] out_descriptor_count
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DESC,
    TRAILER
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [2:0]            word_idx;
  logic [2:0]            word_idx_next;
  logic [255:0]          held_descriptor;
  logic [COORD_BITS-1:0] held_x;
  logic [COORD_BITS-1:0] held_y;
  logic [COUNT_BITS-1:0] corner_count;
  logic [COUNT_BITS-1:0] descriptor_count;
  logic                  frame_end_seen;

  logic                  trailer_due;
  logic                  capture;
  logic                  trailer_done;
  logic [15:0]           x_ext;
  logic [15:0]           y_ext;
  logic [15:0]           count_ext;

  assign trailer_due = frame_end_seen && (corner_count == descriptor_count);

  // Zero extension done through variables so that COORD_BITS/COUNT_BITS up to
  // 16 never produce a zero-width replication.
  always_comb begin
    x_ext = '0;
    y_ext = '0;
    count_ext = '0;
    x_ext[COORD_BITS-1:0] = held_x;
    y_ext[COORD_BITS-1:0] = held_y;
    count_ext[COUNT_BITS-1:0] = descriptor_count;
  end

  always_comb begin
    state_next    = state;
    word_idx_next = word_idx;
    out_consume   = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    out_word      = 32'd0;
    capture       = 1'b0;
    trailer_done  = 1'b0;
    case (state)
      IDLE: begin
        // The trailer check wins so a pending descriptor from the next frame
        // cannot slip in ahead of the current frame's trailer.
        if (trailer_due) begin
          state_next = TRAILER;
        end else if (in_valid) begin
          out_consume = 1'b1;
          capture     = 1'b1;
          state_next  = HEADER;
        end
      end
      HEADER: begin
        out_valid = 1'b1;
        out_word  = {y_ext, x_ext};
        if (in_ready) begin
          word_idx_next = 3'd0;
          state_next    = DESC;
        end
      end
      DESC: begin
        out_valid = 1'b1;
        out_word  = held_descriptor[{word_idx, 5'b00000} +: 32];
        out_last  = (word_idx == 3'd7);
        if (in_ready) begin
          word_idx_next = word_idx + 3'd1;
          if (word_idx == 3'd7) begin
            state_next = IDLE;
          end
        end
      end
      TRAILER: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_word  = {16'hFFFF, count_ext};
        if (in_ready) begin
          trailer_done = 1'b1;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      word_idx        <= 3'd0;
      held_descriptor <= '0;
      held_x          <= '0;
      held_y          <= '0;
    end else begin
      state    <= state_next;
      word_idx <= word_idx_next;
      if (capture) begin
        held_descriptor <= in_descriptor;
        held_x          <= in_feature_x;
        held_y          <= in_feature_y;
      end
    end
  end

  // A frame reset clears counters but leaves the holding registers alone, so
  // an in-flight packet (including one captured this very cycle) completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corner_count     <= '0;
      descriptor_count <= '0;
      frame_end_seen   <= 1'b0;
    end else if (in_begin_frame_reset) begin
      corner_count     <= '0;
      descriptor_count <= '0;
      frame_end_seen   <= 1'b0;
    end else begin
      if (in_corner_count_increment) begin
        corner_count <= corner_count + COUNT_BITS'(1);
      end
      if (capture) begin
        descriptor_count <= descriptor_count + COUNT_BITS'(1);
      end
      // A fresh frame end must not be lost if it lands on a trailer transfer.
      if (in_frame_end) begin
        frame_end_seen <= 1'b1;
      end else if (trailer_done) begin
        frame_end_seen <= 1'b0;
      end
    end
  end

  assign out_busy             = (state != IDLE);
  assign out_descriptor_count = descriptor_count;

endmodule

// File: tb/tb_orb_descriptor_reader.sv
// tb/tb_orb_descriptor_reader.sv - self-checking bench for orb_descriptor_reader

module tb_orb_descriptor_reader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_begin_frame_reset = 1'b0;
  logic         in_corner_count_increment = 1'b0;
  logic         in_frame_end = 1'b0;
  logic         in_valid = 1'b0;
  logic [255:0] in_descriptor = '0;
  logic [10:0]  in_feature_x = '0;
  logic [10:0]  in_feature_y = '0;
  logic         out_consume;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_last;
  logic         in_ready = 1'b1;
  logic         out_busy;
  logic [15:0]  out_descriptor_count;

  orb_descriptor_reader #(.COORD_BITS(11), .COUNT_BITS(16)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .in_begin_frame_reset      (in_begin_frame_reset),
    .in_corner_count_increment (in_corner_count_increment),
    .in_frame_end              (in_frame_end),
    .in_valid                  (in_valid),
    .in_descriptor             (in_descriptor),
    .in_feature_x              (in_feature_x),
    .in_feature_y              (in_feature_y),
    .out_consume               (out_consume),
    .out_word                  (out_word),
    .out_valid                 (out_valid),
    .out_last                  (out_last),
    .in_ready                  (in_ready),
    .out_busy                  (out_busy),
    .out_descriptor_count      (out_descriptor_count)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          failed = 0;
  int          consume_cnt = 0;
  int          stable_err = 0;
  int          m_desc = 0;
  bit          rnd_ready = 1'b0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [32:0] prev_beat = '0;

  // Monitor: samples mid-cycle; a beat is recorded when the upcoming edge
  // will transfer it. Also checks that stalled beats stay put.
  always @(negedge clk) begin
    if (out_consume) consume_cnt <= consume_cnt + 1;
    if (stall_prev && !(out_valid === 1'b1 && {out_last, out_word} === prev_beat))
      stable_err <= stable_err + 1;
    stall_prev <= out_valid && !in_ready;
    prev_beat  <= {out_last, out_word};
    if (out_valid && in_ready) got_q.push_back({out_last, out_word});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_desc();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // Reference packet: header {y, x} zero-extended, then the descriptor in
  // 32-bit slices from the bottom up; only the final slice carries last.
  function automatic void add_packet(input logic [255:0] d, input logic [10:0] x,
                                     input logic [10:0] y);
    exp_q.push_back({1'b0, 5'd0, y, 5'd0, x});
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), d[32*i +: 32]});
    m_desc++;
  endfunction

  function automatic void add_trailer();
    exp_q.push_back({1'b1, 16'hFFFF, 16'(m_desc)});
  endfunction

  task automatic push_desc(input logic [255:0] d, input logic [10:0] x, input logic [10:0] y);
    bit seen = 1'b0;
    in_descriptor = d;
    in_feature_x  = x;
    in_feature_y  = y;
    in_valid      = 1'b1;
    for (int i = 0; i < 500 && !seen; i++) begin
      in_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_consume) seen = 1'b1;
      step();
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    chk("consume_seen", 64'(seen), 64'd1);
    add_packet(d, x, y);
  endtask

  task automatic pulse_begin();
    in_begin_frame_reset = 1'b1;
    step();
    in_begin_frame_reset = 1'b0;
    m_desc = 0;
  endtask

  task automatic drain_check(input string tag);
    logic [32:0] g;
    logic [32:0] e;
    for (int i = 0; i < 3000 && got_q.size() < exp_q.size(); i++) begin
      in_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
    end
    in_ready = 1'b1;
    chk({tag, "_timeout"}, 64'(got_q.size() >= exp_q.size()), 64'd1);
    repeat (12) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      chk(tag, 64'(g), 64'(e));
    end
    chk({tag, "_extra"}, 64'(got_q.size()), 64'd0);
    got_q.delete();
  endtask

  initial begin
    logic [255:0] ramp;
    int c0;

    // Reset state
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_word", 64'(out_word), 64'd0);
    chk("rst_consume", 64'(out_consume), 64'd0);
    chk("rst_busy", 64'(out_busy), 64'd0);
    chk("rst_count", 64'(out_descriptor_count), 64'd0);
    reset = 1'b0;
    step();

    // Single descriptor, byte ramp, ready held high
    for (int i = 0; i < 32; i++) ramp[8*i +: 8] = 8'(i);
    pulse_begin();
    rnd_ready = 1'b0;
    push_desc(ramp, 11'd40, 11'd25);
    chk("hdr_latency_valid", 64'(out_valid), 64'd1);
    chk("hdr_word", 64'(out_word), 64'h0019_0028);
    chk("hdr_busy", 64'(out_busy), 64'd1);
    in_corner_count_increment = 1'b1;
    in_frame_end = 1'b1;
    step();
    in_corner_count_increment = 1'b0;
    in_frame_end = 1'b0;
    add_trailer();
    drain_check("single");
    chk("single_consumes", 64'(consume_cnt), 64'd1);
    chk("single_count", 64'(out_descriptor_count), 64'd1);

    // Backpressure: toggle ready; a waiting second descriptor must not be
    // popped until all 9 words of the first packet have transferred.
    push_desc(rand_desc(), 11'($urandom), 11'($urandom));
    in_descriptor = rand_desc();
    in_feature_x  = 11'($urandom);
    in_feature_y  = 11'($urandom);
    in_valid = 1'b1;
    c0 = consume_cnt;
    for (int i = 0; i < 300 && consume_cnt == c0; i++) begin
      in_ready = ~in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("bp_words_before_pop", 64'(got_q.size()), 64'd9);
    add_packet(in_descriptor, in_feature_x, in_feature_y);
    rnd_ready = 1'b1;
    drain_check("bp");
    chk("bp_stable", 64'(stable_err), 64'd0);

    // Trailer waits for drain: 3 corners and frame end before any descriptor
    pulse_begin();
    repeat (3) begin
      in_corner_count_increment = 1'b1;
      step();
      in_corner_count_increment = 1'b0;
      step();
    end
    in_frame_end = 1'b1;
    step();
    in_frame_end = 1'b0;
    repeat (50) step();
    chk("drain_no_early_trailer", 64'(got_q.size()), 64'd0);
    chk("drain_idle", 64'(out_busy), 64'd0);
    repeat (3) push_desc(rand_desc(), 11'($urandom), 11'($urandom));
    add_trailer();
    drain_check("drain");
    chk("drain_stable", 64'(stable_err), 64'd0);

    // Empty frame
    rnd_ready = 1'b0;
    pulse_begin();
    repeat (5) step();
    chk("empty_no_trailer_yet", 64'(got_q.size()), 64'd0);
    in_frame_end = 1'b1;
    step();
    in_frame_end = 1'b0;
    add_trailer();
    drain_check("empty");

    // Frame reset (with a simultaneous corner increment) during DESC k=3
    in_corner_count_increment = 1'b1;
    step();
    step();
    in_corner_count_increment = 1'b0;
    push_desc(rand_desc(), 11'($urandom), 11'($urandom));
    for (int i = 0; i < 50 && got_q.size() < 4; i++) step();
    chk("frst_at_k3", 64'(got_q.size()), 64'd4);
    in_corner_count_increment = 1'b1;
    pulse_begin();
    in_corner_count_increment = 1'b0;
    drain_check("frst_packet");
    chk("frst_count", 64'(out_descriptor_count), 64'd0);
    in_frame_end = 1'b1;
    step();
    in_frame_end = 1'b0;
    add_trailer();
    drain_check("frst_trailer");

    // Asynchronous reset mid-packet
    push_desc(rand_desc(), 11'($urandom), 11'($urandom));
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(out_busy), 64'd0);
    chk("arst_count", 64'(out_descriptor_count), 64'd0);
    step();
    reset = 1'b0;
    step();
    got_q.delete();
    exp_q.delete();
    m_desc = 0;
    push_desc(rand_desc(), 11'($urandom), 11'($urandom));
    drain_check("arst_fresh");
    chk("arst_fresh_count", 64'(out_descriptor_count), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/orb_descriptor_reader.md
Name: orb_descriptor_reader

Overview:
- Drains the ORB descriptor output of the corners/descriptor pipeline.
- Pops one descriptor at a time with a consume pulse, then serialises it as a 9-word, 32-bit stream packet: one coordinate header word followed by 8 descriptor words.
- Counts corners reported against descriptors read. Once the frame has ended and every reported corner has been drained, it emits a single frame trailer word.
- Sits between the descriptor arbitrator and the host/DMA word stream.

Parameters:
- COORD_BITS, 11, width of feature x/y coordinates; legal range 1..15.
- COUNT_BITS, 16, width of the corner and descriptor counters; legal range 1..16.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_begin_frame_reset  in  1  start-of-frame pulse; clears the frame counters and flags
- in_corner_count_increment  in  1  one corner will produce a descriptor
- in_frame_end  in  1  last pixel of the frame has been processed
- in_valid  in  1  a descriptor is available at the head of the upstream FIFO
- in_descriptor  in  256  descriptor bits
- in_feature_x  in  COORD_BITS  feature x coordinate
- in_feature_y  in  COORD_BITS  feature y coordinate
- out_consume  out  1  pop the upstream FIFO
- out_word  out  32  stream data
- out_valid  out  1  stream data valid
- out_last  out  1  final word of the current packet
- in_ready  in  1  downstream accepts the word
- out_busy  out  1  FSM is not in IDLE
- out_descriptor_count  out  COUNT_BITS  descriptors read in the current frame

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. All outputs are 0. Both counters are 0. frame_end_seen is 0.
- FSM states: IDLE, HEADER, DESC, TRAILER.
- Word transfer rule: a word transfers when out_valid && in_ready.
  - While out_valid is high and in_ready is low, out_word and out_last hold stable.
- IDLE, trailer check (takes priority):
  - Condition: frame_end_seen && corner_count == descriptor_count.
  - Action: go to TRAILER.
- IDLE, descriptor capture (when the trailer condition is false):
  - Condition: in_valid.
  - out_consume is asserted combinationally for exactly this cycle.
  - Latch in_descriptor, in_feature_x and in_feature_y into holding registers.
  - descriptor_count increments.
  - Go to HEADER.
- out_consume is never asserted outside IDLE.
- HEADER:
  - out_valid = 1.
  - out_word = {zero-extended y to 16 bits, zero-extended x to 16 bits}. Bit 31 is therefore always 0.
  - On transfer, go to DESC with word index k = 0.
- DESC:
  - out_word = held_descriptor[32k+31:32k].
  - out_last = 1 when k = 7.
  - On transfer: k increments. At k = 7, go to IDLE.
- TRAILER:
  - out_word = {16'hFFFF, zero-extended descriptor_count}.
  - out_last = 1.
  - On transfer: clear frame_end_seen, go to IDLE.
- Latency and throughput:
  - Capture happens in cycle N; the header is valid in cycle N+1.
  - With in_ready held high, one descriptor completes every 10 cycles: 1 IDLE cycle plus 9 words.
- Counters:
  - corner_count increments on in_corner_count_increment.
  - Both counters wrap modulo 2^COUNT_BITS.
  - in_frame_end sets frame_end_seen.
  - A corner increment and a frame end in the same cycle are both honoured.
- in_begin_frame_reset:
  - Synchronously clears corner_count, descriptor_count and frame_end_seen.
  - Takes priority over a simultaneous increment, frame end or capture count. The captured descriptor is still emitted, and descriptor_count reads 0 afterwards.
  - Does not abort an in-flight packet; the packet completes unchanged.
- Frame with zero corners: once in_frame_end is seen, the trailer is emitted with count 0.
- Asynchronous reset mid-packet: the packet is truncated. out_valid drops immediately. The downstream must discard the partial packet.
- out_busy = (state != IDLE).

Test Plan:
- Single descriptor with in_ready = 1:
  - Stimulus: x=40, y=25, descriptor = 256'h{8'h00..8'h1F} byte ramp, in_valid for one capture, then 1 corner increment and in_frame_end.
  - Expected: out_consume high for 1 cycle; words 0x0019_0028, 0x03020100, …, 0x1F1E1D1C with out_last on word 9.
  - Then trailer 0xFFFF_0001 with out_last.
- Backpressure:
  - Stimulus: toggle in_ready every cycle during a packet.
  - Expected: each word is held stable until transfer; exactly 9 transfers; no second out_consume before the packet ends.
- Trailer waits for drain:
  - Stimulus: 3 corner increments, then in_frame_end, with descriptors arriving 50 cycles later.
  - Expected: no trailer until the 3rd packet completes; then 0xFFFF_0003.
- Empty frame:
  - Stimulus: in_begin_frame_reset, then in_frame_end only.
  - Expected: only trailer 0xFFFF_0000.
- Frame reset mid-packet:
  - Stimulus: in_begin_frame_reset during DESC k=3.
  - Expected: the packet completes all 9 words; out_descriptor_count = 0 afterwards.
- Asynchronous reset mid-packet:
  - Stimulus: assert reset mid-packet.
  - Expected: out_valid = 0 and out_busy = 0 immediately; the next capture starts a fresh header.
